// File: rtl/bicubic_pkg.sv
// Shared constants and types for the bicubic upscaler datapath.
// The weight-code table is used by reference models in the benches.
package bicubic_pkg;

  localparam int BICUBIC_TAPS          = 4;
  localparam int BICUBIC_NORM_SHIFT    = 11;
  localparam int PIX_MAX               = 255;
  localparam int BICUBIC_PRODUCT_WIDTH = 24;

  // Signed stage-1 multiplier product.
  typedef logic signed [BICUBIC_PRODUCT_WIDTH-1:0] bicubic_product_t;

  // 3-bit weight codes 0..7; each 4-tap weight set sums to 2048.
  localparam int BICUBIC_WEIGHT [8] = '{-21, -135, -147, -225, 235, 873, 1535, 1981};

endpackage

// File: rtl/bicubic_norm_clamp.sv
// Combinational normalise-and-saturate: arithmetic right shift of a signed
// accumulator by NORM_SHIFT, then clamp to 0..PIX_MAX as a 9-bit value.
// Optional round-half-up before the shift: define BICUBIC_ACCUM_ROUND_EN.
// Shared by stage 1 and stage 2 of the upscaler.
module bicubic_norm_clamp
  import bicubic_pkg::*;
#(
  parameter int ACC_WIDTH  = BICUBIC_PRODUCT_WIDTH + 2,
  parameter int NORM_SHIFT = BICUBIC_NORM_SHIFT
) (
  input  logic signed [ACC_WIDTH-1:0] i_sum,
  output logic        [8:0]           o_pixel
);

  localparam logic signed [ACC_WIDTH:0] MAX_S = (ACC_WIDTH+1)'(PIX_MAX);

  // One guard bit so the rounding bias can never wrap the sum.
  logic signed [ACC_WIDTH:0] w_ext;
  logic signed [ACC_WIDTH:0] w_biased;
  logic signed [ACC_WIDTH:0] w_norm;

  assign w_ext = {i_sum[ACC_WIDTH-1], i_sum};

`ifdef BICUBIC_ACCUM_ROUND_EN
  localparam logic signed [ACC_WIDTH:0] ROUND_BIAS =
    {{(ACC_WIDTH-NORM_SHIFT+1){1'b0}}, 1'b1, {(NORM_SHIFT-1){1'b0}}};
  assign w_biased = w_ext + ROUND_BIAS;
`else
  assign w_biased = w_ext;
`endif

  assign w_norm = w_biased >>> NORM_SHIFT;

  // Saturate the normalised value into the 0..PIX_MAX pixel range.
  always_comb begin
    // NOTE: o_pixel gets a default first so no branch can leave it unassigned (no latch).
    o_pixel = '0;
    if (w_norm[ACC_WIDTH]) begin
      o_pixel = '0;
    end else if (w_norm > MAX_S) begin
      o_pixel = 9'(PIX_MAX);
    end else begin
      o_pixel = w_norm[8:0];
    end
  end

endmodule

// File: rtl/bicubic_accum_stage1.sv
// Stage-1 accumulator of the bicubic upscaler: sums TAPS signed products per
// pixel, normalises/saturates via bicubic_norm_clamp, and hands the pixel to
// stage 2 through a one-entry valid/ready output register.
// Optional rounding build: define BICUBIC_ACCUM_ROUND_EN.
module bicubic_accum_stage1
  import bicubic_pkg::*;
#(
  parameter int INTER_PRODUCT_WIDTH = BICUBIC_PRODUCT_WIDTH,
  parameter int TAPS                = BICUBIC_TAPS,
  parameter int NORM_SHIFT          = BICUBIC_NORM_SHIFT,
  parameter int ACC_WIDTH           = INTER_PRODUCT_WIDTH + 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic signed [INTER_PRODUCT_WIDTH-1:0] in_product,
  input  logic                                  in_last,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic        [8:0]                     out_pixel,
  output logic                                  err_frame
);

  localparam int               CNT_W    = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(TAPS - 1);

  logic        [CNT_W-1:0]     r_tap_cnt;
  logic signed [ACC_WIDTH-1:0] r_acc;
  logic                        r_out_valid;
  logic        [8:0]           r_out_pixel;
  logic                        r_err_frame;

  logic                        w_accept;
  logic                        w_take;
  logic                        w_first_tap;
  logic                        w_last_tap;
  logic                        w_final;
  logic signed [ACC_WIDTH-1:0] w_prod_ext;
  logic signed [ACC_WIDTH-1:0] w_sum;
  logic        [8:0]           w_pixel;

  // Only the final tap can stall, and only while an untaken result is pending.
  assign w_last_tap  = (r_tap_cnt == LAST_TAP);
  assign w_first_tap = (r_tap_cnt == '0);
  assign in_ready    = !w_last_tap || !r_out_valid || out_ready;
  assign w_accept    = in_valid && in_ready;
  assign w_take      = r_out_valid && out_ready;
  assign w_final     = w_accept && w_last_tap;

  // Tap 0 restarts the sum, so no separate clear cycle is needed between pixels.
  assign w_prod_ext = {{(ACC_WIDTH-INTER_PRODUCT_WIDTH){in_product[INTER_PRODUCT_WIDTH-1]}},
                       in_product};
  assign w_sum      = w_first_tap ? w_prod_ext : (r_acc + w_prod_ext);

  bicubic_norm_clamp #(
    .ACC_WIDTH  (ACC_WIDTH),
    .NORM_SHIFT (NORM_SHIFT)
  ) u_norm_clamp (
    .i_sum   (w_sum),
    .o_pixel (w_pixel)
  );

  // Tap counter and running sum advance on every accepted beat.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (rst) begin
      r_tap_cnt <= '0;
      r_acc     <= '0;
    end else if (w_accept) begin
      r_tap_cnt <= w_last_tap ? '0 : r_tap_cnt + 1'b1;
      r_acc     <= w_sum;
    end
  end

  // One-entry output register: a new final tap overrides a same-cycle take.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_pixel <= '0;
    end else if (w_final) begin
      r_out_valid <= 1'b1;
      r_out_pixel <= w_pixel;
    end else if (w_take) begin
      r_out_valid <= 1'b0;
    end
  end

  // Sticky framing error: in_last must coincide with the counter's final tap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_frame <= 1'b0;
    end else if (w_accept && (in_last != w_last_tap)) begin
      r_err_frame <= 1'b1;
    end
  end

  assign out_valid = r_out_valid;
  assign out_pixel = r_out_pixel;
  assign err_frame = r_err_frame;

endmodule
